seq_det_prog: RTL
=================

Name: seq_det_prog

Overview:
Parametrised, run-time-programmable serial sequence detector, the successor to the fixed "101" detector.
- Compares a serial bit stream against a PAT_W-bit pattern loaded over a config port.
- Supports overlapping and non-overlapping detection, gated input valid, and a saturating match counter.
- Sits after serial front-ends (UART/SPI deserialisers, line decoders) as a frame-sync / marker detector.

Parameters:
PAT_W, 3, pattern length in bits (2..32)
CNT_W, 8, width of match counter
RST_PAT, 3'b101, pattern value after reset (PAT_W bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  detector enable; 0 holds window, fill count and state
in_valid  input  1  qualifies in_bit this cycle
in_bit  input  1  serial data; first-received bit compared with pattern[PAT_W-1]
cfg_we  input  1  load cfg_pattern/cfg_overlap; restarts detection
cfg_pattern  input  PAT_W  new pattern
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt and cnt_sat
match  output  1  one-cycle pulse, pattern completed
match_cnt  output  CNT_W  number of matches, saturating
cnt_sat  output  1  sticky, match_cnt reached all-ones

Behaviour:
- Reset (async, rst=1): window=0, fill=0, pattern=RST_PAT, overlap=1, state=IDLE, match=0, match_cnt=0, cnt_sat=0.
- Window is a PAT_W-bit shift register. On an accepted bit: window <= {window[PAT_W-2:0], in_bit}. Newest bit goes into the LSB.
- fill counts accepted bits since restart and saturates at PAT_W.
- An accepted bit requires en & in_valid & !cfg_we.
- FSM states:
  - IDLE: entered on reset or when en=0; nothing is shifted.
  - FILL: en=1 and fill<PAT_W.
  - DETECT: fill==PAT_W.
  - Transitions: IDLE->FILL when en=1. FILL->DETECT on the bit making fill==PAT_W. Any state ->IDLE when en=0; window and fill are retained, and re-enable resumes FILL or DETECT according to fill.
- Hit condition: accepted bit, fill (including this bit) == PAT_W, and the next window == pattern.
- match is registered and asserts the cycle after the completing bit's clock edge. One cycle wide.
- Overlap=1: after a hit, fill stays at PAT_W, so the next bit can complete a new match.
- Overlap=0: after a hit, fill <= 0; the next match needs PAT_W fresh bits.
- cfg_we: pattern and overlap are latched, window=0, fill=0, state=FILL if en else IDLE. cfg_we beats in_valid in the same cycle (bit discarded, no match).
- match_cnt increments by 1 per hit and holds at 2^CNT_W-1. cnt_sat sets when the counter reaches all-ones and stays set until cnt_clr or rst.
- cnt_clr in the same cycle as a hit: the clear wins (match_cnt=0, cnt_sat=0), but the match pulse is still issued.
- in_valid=0 cycles are ignored completely; gaps do not break a partial sequence.
- Reset mid-sequence discards the partial window and restores RST_PAT.

Optional Feature:
SEQ_DET_MASK_EN
- Defined: adds input cfg_mask[PAT_W-1:0], latched on cfg_we; reset value all-ones. Hit requires ((window ^ pattern) & mask)==0, and mask bits at 0 are don't-care. An all-zero mask matches on every bit once fill==PAT_W.
- Undefined: port absent; exact compare.

Decomposition:
- Package seq_det_pkg holds:
  - state enum (IDLE, FILL, DETECT);
  - localparam for the fill-counter width, $clog2(PAT_W+1);
  - the default pattern constant.
- Sub-module sat_counter (CNT_W; inc, clr, count, sat) for match_cnt and cnt_sat, reusable elsewhere.

Test Plan:
1. Reset, defaults (101, overlap); bits 1,0,1,0,1 with in_valid=1, en=1 -> match after bits 3 and 5; match_cnt=2.
2. cfg_we pattern=101, overlap=0; bits 1,0,1,0,1,0,1 -> match after bits 3 and 7 only; match_cnt=2 (overlap=1 on the same stream gives 3).
3. Bits 1,0,1 with in_valid low for 4 cycles between each bit, plus en=0 for 3 cycles mid-stream -> exactly one match; gaps are ignored.
4. CNT_W=2; drive 5 overlapping matches -> match_cnt sticks at 3, cnt_sat=1. Then cnt_clr on the same cycle as a hit -> match=1, match_cnt=0, cnt_sat=0.
5. PAT_W=4 build, cfg pattern 1101; cfg_we asserted after bits 1,1,0 -> no match on the following 1; a full 1,1,0,1 then matches.
6. Reset asserted asynchronously mid-clock after bits 1,0 -> match=0 and fill=0 immediately; the pattern reverts to RST_PAT. With SEQ_DET_MASK_EN and mask 101, stream 1,1,1 -> match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DETECT = 2'd2
  } det_state_e;

  localparam int PAT_W_MAX = 32;

  // Fill counter must be able to hold the value PAT_W itself.
  localparam int FILL_W_MAX = $clog2(PAT_W_MAX + 1);

  localparam logic [31:0] DEFAULT_PAT = 32'b101;

  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky all-ones flag; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc) begin
      count_d = sat_inc(count_q);
      sat_d   = sat_q | (&count_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_det_prog.sv
// Run-time programmable serial pattern detector with overlap control and saturating hit counter.
// Optional don't-care mask compare is enabled by defining SEQ_DET_MASK_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  window_q, window_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic              overlap_q, overlap_d;
  det_state_e        state_q, state_d;
  logic              match_q, match_d;
  logic [PAT_W-1:0]  cmp_mask;

  logic              accept;
  logic              hit;
  logic [PAT_W-1:0]  window_shift;
  logic [FILL_W-1:0] fill_inc;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0]  mask_q, mask_d;
  assign cmp_mask = mask_q;
`else
  assign cmp_mask = '1;
`endif

  // A hit is judged on the window as it will look after this bit is shifted in.
  always_comb begin
    accept       = en & in_valid & ~cfg_we;
    window_shift = {window_q[PAT_W-2:0], in_bit};
    fill_inc     = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
    hit          = accept && (fill_inc == FULL) &&
                   (((window_shift ^ pattern_q) & cmp_mask) == '0);
  end

  always_comb begin
    window_d  = window_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    state_d   = state_q;
    match_d   = hit;
`ifdef SEQ_DET_MASK_EN
    mask_d    = mask_q;
`endif
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
`ifdef SEQ_DET_MASK_EN
      mask_d    = cfg_mask;
`endif
      window_d  = '0;
      fill_d    = '0;
      state_d   = en ? FILL : IDLE;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      if (accept) begin
        window_d = window_shift;
        fill_d   = (hit && !overlap_q) ? '0 : fill_inc;
      end
      // Re-enable resumes from the retained fill level.
      case (state_q)
        IDLE:    state_d = (fill_d == FULL) ? DETECT : FILL;
        FILL:    if (fill_d == FULL) state_d = DETECT;
        DETECT:  if (fill_d != FULL) state_d = FILL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q  <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PAT;
      overlap_q <= 1'b1;
      state_q   <= IDLE;
      match_q   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= '1;
`endif
    end else begin
      window_q  <= window_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      state_q   <= state_d;
      match_q   <= match_d;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign match = match_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (cnt_clr),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

endmodule
